stage_sequencer: RTL and testbench
==================================

Name: stage_sequencer

Overview:
- Controlled replacement for the free-running four-phase stage generator.
- Sequences the four instruction stages in order:
  - 0: fetch/expand
  - 1: read vr_value
  - 2: read vrw_value
  - 3: write vw_value/pc
- Each stage is held until the datapath acknowledges it. Run, single-step, halt, a per-stage timeout fault and a retired-instruction counter are provided.
- Sits between the system clock/reset and the CPU datapath; owns the clk[0:3]/clk_stage contract.

Parameters:
- CNT_W, 16, width of retired-instruction counter instr_count
- TIMEOUT, 64, max cycles a stage may wait for stage_ready before fault (must be >= 1)
- TO_W, 7, width of timeout counter; must hold TIMEOUT

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- run  input  1  level: continuous execution while high
- step  input  1  one-cycle pulse: execute exactly one instruction from HALTED
- halt_req  input  1  level/pulse: stop at next instruction boundary
- stage_ready  input  1  datapath acknowledge for the current stage
- clk_phase  output  4  one-hot stage enable, bit s high while stage s active ([0:3] order)
- clk_stage  output  2  index of the current/last stage
- running  output  1  high in STAGE state
- halted  output  1  high in HALTED state
- fault  output  1  sticky timeout flag, cleared only by reset
- instr_count  output  CNT_W  instructions retired (stage 3 acknowledged)

Behaviour:
- Reset values: state = HALTED, clk_phase = 4'b0000, clk_stage = 0, running = 0, halted = 1, fault = 0, instr_count = 0, internal step_mode = 0, timeout counter = 0.
- FSM states:
  - HALTED: clk_phase = 0.
    - If run = 1 → STAGE with s = 0, step_mode = 0.
    - Else if step = 1 → STAGE with s = 0, step_mode = 1.
    - run has priority over step.
    - fault = 1 blocks both; stay HALTED.
  - STAGE(s): clk_phase = one-hot(s), clk_stage = s, running = 1.
    - Advance condition: stage_ready = 1 in a cycle where clk_phase[s] = 1.
    - Minimum latency is 1 cycle per stage, so the best-case instruction takes 4 cycles.
    - On advance from s < 3: s ← s+1; clk_phase changes on the next edge, with no gap cycle between phases.
    - On advance from s = 3: instr_count increments (wraps modulo 2^CNT_W). Then:
      - → HALTED if halt_req was seen since the instruction started, or run = 0, or step_mode = 1.
      - Else → STAGE(0).
  - halt_req is latched while in STAGE and cleared on entering HALTED. The instruction in flight always completes; stages are never aborted.
- Timeout:
  - The counter resets to 0 on every stage entry and increments each cycle without an advance.
  - When the counter reaches TIMEOUT-1 without stage_ready: fault ← 1 and → HALTED. instr_count is unchanged, and clk_stage keeps the faulting stage index.
- stage_ready outside STAGE is ignored.
- step pulses during STAGE are ignored.
- run falling mid-instruction is equivalent to halt at the boundary.
- Asynchronous reset mid-stage forces the reset values immediately; the instruction is abandoned.
- All outputs are registered (no combinational input→output paths).

Decomposition:
- Shared package holds:
  - stage index constants STG_FETCH = 0, STG_VR = 1, STG_VRW = 2, STG_WRITE = 3.
  - state enum {HALTED, STAGE}.
  - the one-hot encode function used by datapath stage decoders.
- One natural sub-module: stage_timeout_counter (load on stage entry, count, expire flag).

Test Plan:
- Reset then run = 1, stage_ready tied 1:
  - clk_phase cycles 1000, 0100, 0010, 0001 one cycle each; clk_stage 0,1,2,3.
  - instr_count = 3 after 12 cycles.
- run = 1, stage_ready low 5 cycles in stage 1:
  - clk_phase holds 0100 for 6 cycles.
  - Total instruction is 9 cycles; instr_count +1.
- From HALTED, one-cycle step pulse with ready = 1:
  - Exactly one instruction executes (4 cycles), then halted = 1; instr_count = 1.
  - A second step gives 2.
- run = 1, halt_req pulse during stage 1:
  - Stages 2 and 3 still complete, then HALTED; instr_count +1.
  - No further clk_phase activity.
- TIMEOUT = 4, stage_ready never asserted in stage 2:
  - After 4 cycles in stage 2: fault = 1, halted = 1, clk_stage = 2, instr_count unchanged.
  - run/step ignored until reset.
- Assert reset during stage 3 with CNT_W = 4 and instr_count = 15:
  - All outputs go to reset values asynchronously.
  - Separately, completing stage 3 from instr_count = 15 (no reset) wraps instr_count to 0.

Source files
------------

// File: rtl/stage_sequencer_pkg.sv
// Shared stage indices, sequencer state encoding and the stage one-hot encoder
// used by both the sequencer and the datapath stage decoders.
package stage_sequencer_pkg;

    localparam logic [1:0] STG_FETCH = 2'd0;
    localparam logic [1:0] STG_VR    = 2'd1;
    localparam logic [1:0] STG_VRW   = 2'd2;
    localparam logic [1:0] STG_WRITE = 2'd3;

    typedef enum logic {
        HALTED = 1'b0,
        STAGE  = 1'b1
    } seq_state_e;

    // Bit s of the result (in [0:3] order) is set for stage s.
    function automatic logic [0:3] stage_onehot(input logic [1:0] stg);
        logic [0:3] oh;
        oh      = '0;
        oh[stg] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/stage_sequencer_timeout_counter.sv
// Per-stage wait counter: cleared on stage entry, counts stalled cycles and
// flags expiry once TIMEOUT stalled cycles have been spent in one stage.
module stage_timeout_counter #(
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic count_en,
    output logic expire
);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (count_en) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/stage_sequencer.sv
// Handshaked four-stage instruction sequencer with run/step/halt control,
// sticky per-stage timeout fault and a retired-instruction counter.
module stage_sequencer
    import stage_sequencer_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    input  logic             halt_req,
    input  logic             stage_ready,
    output logic [0:3]       clk_phase,
    output logic [1:0]       clk_stage,
    output logic             running,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] instr_count
);

    seq_state_e       state_q, state_d;
    logic [1:0]       stage_q, stage_d;
    logic             step_mode_q, step_mode_d;
    logic             halt_seen_q, halt_seen_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [0:3]       phase_q, phase_d;
    logic             running_q, running_d;
    logic             halted_q, halted_d;

    logic             to_count_en;
    logic             to_expire;

    // Count only stalled cycles; any advance, fault or idle cycle re-arms it.
    assign to_count_en = (state_q == STAGE) && !stage_ready && !to_expire;

    stage_timeout_counter #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timeout (
        .clk      (clk),
        .rst      (reset),
        .load     (!to_count_en),
        .count_en (to_count_en),
        .expire   (to_expire)
    );

    always_comb begin
        state_d     = state_q;
        stage_d     = stage_q;
        step_mode_d = step_mode_q;
        halt_seen_d = halt_seen_q;
        fault_d     = fault_q;
        count_d     = count_q;

        case (state_q)
            HALTED: begin
                halt_seen_d = 1'b0;
                if (!fault_q) begin
                    if (run) begin
                        state_d     = STAGE;
                        stage_d     = STG_FETCH;
                        step_mode_d = 1'b0;
                    end else if (step) begin
                        state_d     = STAGE;
                        stage_d     = STG_FETCH;
                        step_mode_d = 1'b1;
                    end
                end
            end
            STAGE: begin
                if (halt_req) begin
                    halt_seen_d = 1'b1;
                end
                if (stage_ready) begin
                    if (stage_q != STG_WRITE) begin
                        stage_d = stage_q + 2'd1;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                        // halt_req in the retiring cycle itself also counts
                        if (halt_seen_q || halt_req || !run || step_mode_q) begin
                            state_d     = HALTED;
                            halt_seen_d = 1'b0;
                        end else begin
                            stage_d = STG_FETCH;
                        end
                    end
                end else if (to_expire) begin
                    fault_d     = 1'b1;
                    state_d     = HALTED;
                    halt_seen_d = 1'b0;
                end
            end
            default: begin
                state_d = HALTED;
            end
        endcase

        phase_d   = (state_d == STAGE) ? stage_onehot(stage_d) : 4'b0000;
        running_d = (state_d == STAGE);
        halted_d  = (state_d == HALTED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= HALTED;
            stage_q     <= STG_FETCH;
            step_mode_q <= 1'b0;
            halt_seen_q <= 1'b0;
            fault_q     <= 1'b0;
            count_q     <= '0;
            phase_q     <= 4'b0000;
            running_q   <= 1'b0;
            halted_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            step_mode_q <= step_mode_d;
            halt_seen_q <= halt_seen_d;
            fault_q     <= fault_d;
            count_q     <= count_d;
            phase_q     <= phase_d;
            running_q   <= running_d;
            halted_q    <= halted_d;
        end
    end

    assign clk_phase   = phase_q;
    assign clk_stage   = stage_q;
    assign running     = running_q;
    assign halted      = halted_q;
    assign fault       = fault_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: per-cycle vector table plus hand-written
// sequences for counter wrap, asynchronous reset and the timeout fault.
module tb_stage_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance: small counter for wrap tests, long timeout
    logic       rst = 1'b1;
    logic       run = 1'b0, step = 1'b0, hreq = 1'b0, rdy = 1'b0;
    logic [0:3] phase;
    logic [1:0] stg;
    logic       running, halted, fault;
    logic [3:0] count;

    stage_sequencer #(.CNT_W(4), .TIMEOUT(64), .TO_W(7)) u_dut (
        .clk(clk), .reset(rst), .run(run), .step(step), .halt_req(hreq),
        .stage_ready(rdy), .clk_phase(phase), .clk_stage(stg),
        .running(running), .halted(halted), .fault(fault), .instr_count(count)
    );

    // timeout instance
    logic        rst2 = 1'b1;
    logic        run2 = 1'b0, step2 = 1'b0, hreq2 = 1'b0, rdy2 = 1'b0;
    logic [0:3]  phase2;
    logic [1:0]  stg2;
    logic        running2, halted2, fault2;
    logic [15:0] count2;

    stage_sequencer #(.CNT_W(16), .TIMEOUT(4), .TO_W(3)) u_to (
        .clk(clk), .reset(rst2), .run(run2), .step(step2), .halt_req(hreq2),
        .stage_ready(rdy2), .clk_phase(phase2), .clk_stage(stg2),
        .running(running2), .halted(halted2), .fault(fault2), .instr_count(count2)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       run, step, hreq, rdy;
        logic [3:0] phase;
        logic [1:0] stg;
        logic       running, halted;
        logic [3:0] count;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic s, input logic h, input logic y,
                                input logic [3:0] p, input logic [1:0] st, input logic rn,
                                input logic hl, input logic [3:0] c);
        vec_t v;
        v.run = r; v.step = s; v.hreq = h; v.rdy = y;
        v.phase = p; v.stg = st; v.running = rn; v.halted = hl; v.count = c;
        return v;
    endfunction

    // drive run with ready tied high for n instructions, dropping run in the last stage 3
    task automatic do_instrs(input int n);
        @(negedge clk);
        run = 1'b1; rdy = 1'b1;
        repeat (4 * n) @(negedge clk);
        run = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        // free run, ready tied high: 3 instructions
        vecs.push_back(mk(1,0,0,1, 4'b0000,0,0,1,0));
        for (int i = 0; i < 3; i++) begin
            vecs.push_back(mk(1,0,0,1, 4'b1000,0,1,0,4'(i)));
            vecs.push_back(mk(1,0,0,1, 4'b0100,1,1,0,4'(i)));
            vecs.push_back(mk(1,0,0,1, 4'b0010,2,1,0,4'(i)));
            vecs.push_back(mk(1,0,0,1, 4'b0001,3,1,0,4'(i)));
        end
        // stage 1 stalled 5 cycles, run dropped in stage 3
        vecs.push_back(mk(1,0,0,1, 4'b1000,0,1,0,3));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(1,0,0,0, 4'b0100,1,1,0,3));
        vecs.push_back(mk(1,0,0,1, 4'b0100,1,1,0,3));
        vecs.push_back(mk(1,0,0,1, 4'b0010,2,1,0,3));
        vecs.push_back(mk(0,0,0,1, 4'b0001,3,1,0,3));
        // single step; a step pulse mid-instruction is ignored
        vecs.push_back(mk(0,1,0,1, 4'b0000,3,0,1,4));
        vecs.push_back(mk(0,0,0,1, 4'b1000,0,1,0,4));
        vecs.push_back(mk(0,0,0,1, 4'b0100,1,1,0,4));
        vecs.push_back(mk(0,1,0,1, 4'b0010,2,1,0,4));
        vecs.push_back(mk(0,0,0,1, 4'b0001,3,1,0,4));
        vecs.push_back(mk(0,0,0,1, 4'b0000,3,0,1,5));
        // second step
        vecs.push_back(mk(0,1,0,0, 4'b0000,3,0,1,5));
        vecs.push_back(mk(0,0,0,1, 4'b1000,0,1,0,5));
        vecs.push_back(mk(0,0,0,1, 4'b0100,1,1,0,5));
        vecs.push_back(mk(0,0,0,1, 4'b0010,2,1,0,5));
        vecs.push_back(mk(0,0,0,1, 4'b0001,3,1,0,5));
        // run with halt_req pulse in stage 1: instruction completes, then halts
        vecs.push_back(mk(1,0,0,1, 4'b0000,3,0,1,6));
        vecs.push_back(mk(1,0,0,1, 4'b1000,0,1,0,6));
        vecs.push_back(mk(1,0,1,1, 4'b0100,1,1,0,6));
        vecs.push_back(mk(1,0,0,1, 4'b0010,2,1,0,6));
        vecs.push_back(mk(1,0,0,1, 4'b0001,3,1,0,6));
        vecs.push_back(mk(0,0,0,1, 4'b0000,3,0,1,7));
        vecs.push_back(mk(0,0,0,1, 4'b0000,3,0,1,7));

        #12;
        chk("reset_halted", halted, 1'b1);
        chk("reset_phase", phase, 4'b0000);
        chk("reset_count", count, 4'd0);
        @(negedge clk);
        rst = 1'b0; rst2 = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            chk($sformatf("v%0d_phase", i), phase, vecs[i].phase);
            chk($sformatf("v%0d_stage", i), stg, vecs[i].stg);
            chk($sformatf("v%0d_running", i), running, vecs[i].running);
            chk($sformatf("v%0d_halted", i), halted, vecs[i].halted);
            chk($sformatf("v%0d_count", i), count, vecs[i].count);
            chk($sformatf("v%0d_fault", i), fault, 1'b0);
            run = vecs[i].run; step = vecs[i].step; hreq = vecs[i].hreq; rdy = vecs[i].rdy;
        end

        // bring count to 15, then reset asynchronously during stage 3
        do_instrs(8);
        chk("to15_count", count, 4'd15);
        chk("to15_halted", halted, 1'b1);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_phase", phase, 4'b0001);
        chk("pre_rst_count", count, 4'd15);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_phase", phase, 4'b0000);
        chk("async_rst_stage", stg, 2'd0);
        chk("async_rst_running", running, 1'b0);
        chk("async_rst_halted", halted, 1'b1);
        chk("async_rst_count", count, 4'd0);
        chk("async_rst_fault", fault, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // counter wrap without reset
        do_instrs(15);
        chk("wrap_pre_count", count, 4'd15);
        do_instrs(1);
        chk("wrap_count", count, 4'd0);
        chk("wrap_halted", halted, 1'b1);

        // timeout: ready never returns in stage 2
        @(negedge clk);
        run2 = 1'b1; rdy2 = 1'b1;
        repeat (3) @(negedge clk);
        rdy2 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("to_hold%0d_phase", k), phase2, 4'b0010);
            chk($sformatf("to_hold%0d_fault", k), fault2, 1'b0);
            @(negedge clk);
        end
        chk("to_fault", fault2, 1'b1);
        chk("to_halted", halted2, 1'b1);
        chk("to_stage", stg2, 2'd2);
        chk("to_count", count2, 16'd0);
        chk("to_phase", phase2, 4'b0000);
        rdy2 = 1'b1; step2 = 1'b1;
        @(negedge clk);
        step2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("to_blocked_halted", halted2, 1'b1);
        chk("to_blocked_phase", phase2, 4'b0000);
        chk("to_blocked_fault", fault2, 1'b1);
        run2 = 1'b0;
        rst2 = 1'b1;
        #1;
        chk("to_rst_fault", fault2, 1'b0);
        chk("to_rst_stage", stg2, 2'd0);
        @(negedge clk);
        rst2 = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
